act_skew_feeder: RTL and testbench

- Upstream feeder for the sys systolic array.
- Accepts one activation column vector (one element per array row) per cycle from the activation buffer over a valid/ready handshake.
- Delays row r by r extra cycles to produce the diagonal wavefront on if_en/if_data.
- Counts vectors per tile and flags done once the last element has entered the array.

---
 rtl/act_skew_feeder.sv | 145 ++++++++++++++
 tb/tb_act_skew_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/act_skew_feeder.sv
// act_skew_feeder
//   Upstream feeder for the systolic array. Takes one activation column
//   vector per cycle from the activation buffer and skews it into a
//   diagonal wavefront. Element r is delayed by r extra cycles. The block
//   counts vectors per tile and pulses done once the last element has
//   entered the array.
//
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
//   in_ready is decoded from registered state only, so it never depends
//   combinationally on in_valid. The source may hold or drop in_valid
//   freely. A cycle without a transfer inserts a bubble in every lane.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   start        tile start pulse, honoured only in IDLE
//   vec_count    vectors in the tile, latched with an honoured start
//   in_valid     in_data holds a valid vector
//   in_ready     feeder accepts a vector this cycle (STREAM only)
//   in_data      activation vector, element r goes to array row r
//   if_en        per-row activation enable into the array
//   if_data      per-row activation data (zero whenever if_en is low)
//   busy         high in STREAM and DRAIN
//   done         one-cycle pulse at the end of a tile
//   dbg_state    current FSM state, for observation only
module act_skew_feeder #(
  parameter int SYS_ROWS   = 4,
  parameter int A_BITWIDTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     vec_count,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [SYS_ROWS-1:0][A_BITWIDTH-1:0]  in_data,
  output logic [SYS_ROWS-1:0]                  if_en,
  output logic [SYS_ROWS-1:0][A_BITWIDTH-1:0]  if_data,
  output logic                                 busy,
  output logic                                 done,
  output logic [1:0]                           dbg_state
);

  localparam int DW = (SYS_ROWS > 1) ? $clog2(SYS_ROWS) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(SYS_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic             done_q, done_d;
  logic             accept;

  assign in_ready  = (state_q == STREAM);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == STREAM) || (state_q == DRAIN);
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drain_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      drain_q     <= drain_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (vec_count != '0) begin
            remaining_d = vec_count;
            state_d     = STREAM;
          end else begin
            // Empty tile: nothing to stream, report completion directly.
            done_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (accept) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end
      end
      DRAIN: begin
        // Wait until the last vector's final element has left the
        // longest lane; done lands one cycle after that element.
        drain_d = drain_q + DW'(1);
        if (drain_q == DRAIN_LAST) begin
          state_d = IDLE;
          drain_d = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Lane r is an (r+1)-stage shift register of {en, data}. Stages shift
  // every cycle regardless of state so in-flight data drains on its own.
  for (genvar r = 0; r < SYS_ROWS; r++) begin : g_lane
    logic [r:0]                 en_q;
    logic [r:0][A_BITWIDTH-1:0] d_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        en_q <= '0;
        d_q  <= '0;
      end else begin
        en_q[0] <= accept;
        d_q[0]  <= accept ? in_data[r] : '0;
        for (int k = 1; k <= r; k++) begin
          en_q[k] <= en_q[k-1];
          d_q[k]  <= d_q[k-1];
        end
      end
    end

    assign if_en[r]   = en_q[r];
    assign if_data[r] = d_q[r];
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
module tb_act_skew_feeder;
  localparam int R  = 4;
  localparam int AW = 8;
  localparam int CW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [CW-1:0]        vec_count = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [R-1:0][AW-1:0] in_data = '0;
  logic [R-1:0]         if_en;
  logic [R-1:0][AW-1:0] if_data;
  logic                 busy;
  logic                 done;
  logic [1:0]           dbg_state;

  always #5 clk = ~clk;

  act_skew_feeder #(.SYS_ROWS(R), .A_BITWIDTH(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_count(vec_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .if_en(if_en), .if_data(if_data), .busy(busy), .done(done),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- reference model ----------------
  // Expectations are derived from tile-level rules: which cycles had an
  // accepted vector, when the last one went in, and when done is due.
  bit                   m_stream = 1'b0;
  int                   m_left = 0;
  int                   m_drain_until = -1;
  int                   m_done_at = -1;
  bit                   h_en[int];
  logic [R-1:0][AW-1:0] h_d[int];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_model();
    logic [R-1:0]         e_en;
    logic [R-1:0][AW-1:0] e_d;
    e_en = '0;
    e_d  = '0;
    for (int r = 0; r < R; r++) begin
      if (h_en.exists(cyc - 1 - r)) begin
        e_en[r] = 1'b1;
        e_d[r]  = h_d[cyc - 1 - r][r];
      end
    end
    chk("in_ready", 64'(in_ready), 64'(m_stream));
    chk("busy",     64'(busy),     64'(m_stream || (cyc <= m_drain_until)));
    chk("done",     64'(done),     64'(cyc == m_done_at));
    chk("if_en",    64'(if_en),    64'(e_en));
    chk("if_data",  64'(if_data),  64'(e_d));
  endtask

  task automatic model_update();
    bit idle;
    bit acc;
    idle = !m_stream && (cyc > m_drain_until);
    acc  = m_stream && in_valid;
    if (acc) begin
      h_en[cyc] = 1'b1;
      h_d[cyc]  = in_data;
      m_left--;
      if (m_left == 0) begin
        m_stream      = 1'b0;
        m_drain_until = cyc + R;
        m_done_at     = cyc + R + 1;
      end
    end
    if (idle && start) begin
      if (vec_count != '0) begin
        m_stream = 1'b1;
        m_left   = int'(vec_count);
      end else begin
        m_done_at = cyc + 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge with inputs already applied.
  task automatic cycle();
    check_model();
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive(input bit s, input int vc, input bit v);
    start     = s;
    vec_count = CW'(vc);
    in_valid  = v;
    for (int r = 0; r < R; r++) in_data[r] = AW'($urandom_range(1, 255));
    cycle();
  endtask

  task automatic idle_n(input int n);
    repeat (n) drive(1'b0, 0, 1'b0);
  endtask

  // Asserts reset mid-cycle and checks that outputs clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy",     64'(busy),     64'd0);
    chk("rst_done",     64'(done),     64'd0);
    chk("rst_if_en",    64'(if_en),    64'd0);
    chk("rst_if_data",  64'(if_data),  64'd0);
    m_stream      = 1'b0;
    m_left        = 0;
    m_drain_until = -1;
    m_done_at     = -1;
    h_en.delete();
    h_d.delete();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
  endtask

  // ---------------- single-vector table ----------------
  typedef struct {
    logic        s;
    logic [15:0] vc;
    logic        v;
    logic [31:0] d;
    logic        e_rdy;
    logic [3:0]  e_en;
    logic [31:0] e_d;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t tbl[8];

  task automatic run_table();
    for (int i = 0; i < 8; i++) begin
      start     = tbl[i].s;
      vec_count = tbl[i].vc;
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      chk("tbl_in_ready", 64'(in_ready), 64'(tbl[i].e_rdy));
      chk("tbl_if_en",    64'(if_en),    64'(tbl[i].e_en));
      chk("tbl_if_data",  64'(if_data),  64'(tbl[i].e_d));
      chk("tbl_busy",     64'(busy),     64'(tbl[i].e_busy));
      chk("tbl_done",     64'(done),     64'(tbl[i].e_done));
      cycle();
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    //          s  vc     v  data          rdy en    e_data        busy done
    tbl[0] = '{1'b1, 16'd1, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0, 1'b0};
    tbl[1] = '{1'b0, 16'd0, 1'b1, 32'h04030201, 1'b1, 4'h0, 32'h0,        1'b1, 1'b0};
    tbl[2] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b0, 4'h1, 32'h00000001, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b0, 4'h2, 32'h00000200, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b0, 4'h4, 32'h00030000, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b0, 4'h8, 32'h04000000, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0, 1'b1};
    tbl[7] = '{1'b0, 16'd0, 1'b0, 32'h0,        1'b0, 4'h0, 32'h0,        1'b0, 1'b0};

    @(negedge clk);
    do_reset();
    idle_n(2);

    // single vector
    run_table();
    idle_n(2);

    // burst of three
    drive(1'b1, 3, 1'b0);
    repeat (3) drive(1'b0, 0, 1'b1);
    idle_n(7);

    // bubble in the middle of a two-vector tile
    drive(1'b1, 2, 1'b0);
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b1);
    idle_n(7);

    // zero-length tile
    drive(1'b1, 0, 1'b0);
    idle_n(3);

    // start held high while busy, then a new start in the done cycle
    drive(1'b1, 3, 1'b0);
    repeat (3) drive(1'b1, 9, 1'b1);
    repeat (4) drive(1'b1, 9, 1'b0);
    drive(1'b1, 2, 1'b0);
    repeat (2) drive(1'b0, 0, 1'b1);
    idle_n(8);

    // reset after two accepts of a four-vector tile, then single vector
    drive(1'b1, 4, 1'b0);
    repeat (2) drive(1'b0, 0, 1'b1);
    do_reset();
    idle_n(1);
    run_table();
    idle_n(2);

    // random traffic with occasional mid-tile resets
    repeat (3000) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 5) == 0, $urandom_range(0, 5), $urandom_range(0, 3) != 0);
      end
    end
    idle_n(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
